// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Purpose : groups the start/busy/done handshake, the operands and the result
//           of the serial adder into one bundle.
// Params  : WIDTH - operand/result width in bits (must match the adder).
// Signals : start, sub, a, b, cin   - request side (driven by the master)
//           busy, done, sum, cout   - response side (driven by the adder)
//           ovf                     - signed overflow, present only when
//                                     SERIAL_ADDER_OVF_EN is defined
// Modports: master - the requester; slave - the adder.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Purpose : multi-cycle adder/subtractor. Processes DIGIT bits per clock with a
//           single DIGIT-bit ripple slice and a carry register, so a WIDTH-bit
//           operation takes STEPS = WIDTH/DIGIT RUN cycles.
// Params  : WIDTH (>=1) operand width; DIGIT bits per cycle, must divide WIDTH.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset (aborts any operation)
//           bus  - serial_adder_if.slave:
//                    start/sub/a/b/cin in, busy/done/sum/cout out
//                    (+ ovf when SERIAL_ADDER_OVF_EN is defined)
// Options : SERIAL_ADDER_OVF_EN - adds a registered signed-overflow flag.
// Notes   : sub=1 computes a + ~b + 1 (cin ignored); cout=1 means no borrow.
//           sum/cout only change on the completion edge or on reset.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Slice result: {carry into MSB of slice, slice carry-out, slice sum}
  logic [DIGIT+1:0]       slice_s;
  logic [WIDTH+DIGIT-1:0] r_ext_s;
  logic [WIDTH-1:0]       r_next_s;

  // Ripple-carry DIGIT-bit slice; also reports the carry into its top bit so
  // the final digit can provide the carry into the operand MSB.
  function automatic logic [DIGIT+1:0] digit_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             ci
  );
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[DIGIT-1], c[DIGIT], s};
  endfunction

  // Slice evaluation and result-register shift used on every RUN step
  always_comb begin
    slice_s  = digit_add(a_sh_q[DIGIT-1:0], b_sh_q[DIGIT-1:0], carry_q);
    // Concatenate-then-slice keeps the shift legal when DIGIT == WIDTH.
    r_ext_s  = {slice_s[DIGIT-1:0], r_q};
    r_next_s = r_ext_s[WIDTH+DIGIT-1:DIGIT];
  end

  // Next-state and datapath update for the IDLE/RUN controller
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_d     = r_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    count_d = count_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          r_d     = {WIDTH{1'b0}};
          count_d = {CNT_W{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        r_d     = r_next_s;
        carry_d = slice_s[DIGIT];
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_STEP) begin
          // Completion: publish the result including the current digit.
          sum_d   = r_next_s;
          cout_d  = slice_s[DIGIT];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = slice_s[DIGIT+1] ^ slice_s[DIGIT];
`endif
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      count_q <= count_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Overflow flag register, updated only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder: WIDTH=8 with DIGIT 1 and 4, plus WIDTH=4
// with DIGIT 1, 2 and 4 driven in lockstep over every operand combination.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  serial_adder_if #(.WIDTH(8)) if8_1 ();
  serial_adder_if #(.WIDTH(8)) if8_4 ();
  serial_adder_if #(.WIDTH(4)) if4_1 ();
  serial_adder_if #(.WIDTH(4)) if4_2 ();
  serial_adder_if #(.WIDTH(4)) if4_4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8_1 (.clk(clk), .rst(rst), .bus(if8_1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u8_4 (.clk(clk), .rst(rst), .bus(if8_4));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u4_1 (.clk(clk), .rst(rst), .bus(if4_1));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u4_2 (.clk(clk), .rst(rst), .bus(if4_2));
  serial_adder #(.WIDTH(4), .DIGIT(4)) u4_4 (.clk(clk), .rst(rst), .bus(if4_4));

  // Views of the three 4-bit adders so one loop can check them all
  logic       d4  [3];
  logic       bz4 [3];
  logic       c4  [3];
  logic [3:0] s4  [3];
  int         steps4 [3] = '{4, 2, 1};

  assign d4[0] = if4_1.done;  assign d4[1] = if4_2.done;  assign d4[2] = if4_4.done;
  assign bz4[0] = if4_1.busy; assign bz4[1] = if4_2.busy; assign bz4[2] = if4_4.busy;
  assign c4[0] = if4_1.cout;  assign c4[1] = if4_2.cout;  assign c4[2] = if4_4.cout;
  assign s4[0] = if4_1.sum;   assign s4[1] = if4_2.sum;   assign s4[2] = if4_4.sum;

  logic [7:0] last_sum8;
  logic [4:0] exp4;
  logic [4:0] old4;
  logic [3:0] bb4;
  logic       eovf4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence is bounded, this only guards a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record one check outcome and report failures
  task automatic chk(input string tag, input logic ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 8-bit DIGIT=1 operation: start at the current falling edge,
  // check latency, hold behaviour and the final result.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic ts, input logic [7:0] es,
                      input logic ec, input logic eo);
    if8_1.a = ta; if8_1.b = tb; if8_1.cin = tc; if8_1.sub = ts;
    if8_1.start = 1'b1;
    @(negedge clk);
    if8_1.start = 1'b0;
    chk({tag, "_busy"}, (if8_1.busy) === (1'b1), if8_1.busy, 1'b1);
    chk({tag, "_nodone0"}, (if8_1.done) === (1'b0), if8_1.done, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        chk({tag, "_nodone"}, (if8_1.done) === (1'b0), if8_1.done, 1'b0);
        chk({tag, "_hold"}, (if8_1.sum) === (last_sum8), if8_1.sum, last_sum8);
      end
    end
    chk({tag, "_done"}, (if8_1.done) === (1'b1), if8_1.done, 1'b1);
    chk({tag, "_idle"}, (if8_1.busy) === (1'b0), if8_1.busy, 1'b0);
    chk({tag, "_sum"}, (if8_1.sum) === (es), if8_1.sum, es);
    chk({tag, "_cout"}, (if8_1.cout) === (ec), if8_1.cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, (if8_1.ovf) === (eo), if8_1.ovf, eo);
`else
    if (eo === 1'bx) $display("note: unexpected X overflow expectation");
`endif
    last_sum8 = es;
  endtask

  initial begin
    {if8_1.start, if8_1.sub, if8_1.cin, if8_1.a, if8_1.b} = '0;
    {if8_4.start, if8_4.sub, if8_4.cin, if8_4.a, if8_4.b} = '0;
    {if4_1.start, if4_1.sub, if4_1.cin, if4_1.a, if4_1.b} = '0;
    {if4_2.start, if4_2.sub, if4_2.cin, if4_2.a, if4_2.b} = '0;
    {if4_4.start, if4_4.sub, if4_4.cin, if4_4.a, if4_4.b} = '0;
    last_sum8 = 8'h00;
    old4 = 5'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", (if8_1.busy) === (1'b0), if8_1.busy, 1'b0);
    chk("rst_done", (if8_1.done) === (1'b0), if8_1.done, 1'b0);
    chk("rst_sum", (if8_1.sum) === (8'h00), if8_1.sum, 8'h00);
    chk("rst_cout", (if8_1.cout) === (1'b0), if8_1.cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", (if8_1.ovf) === (1'b0), if8_1.ovf, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // DIGIT=4: 3C + C4 + 1 = 0x101, done after two RUN edges
    if8_4.a = 8'h3C; if8_4.b = 8'hC4; if8_4.cin = 1'b1; if8_4.sub = 1'b0;
    if8_4.start = 1'b1;
    @(negedge clk);
    if8_4.start = 1'b0;
    chk("d4_busy", (if8_4.busy) === (1'b1), if8_4.busy, 1'b1);
    @(negedge clk);
    chk("d4_nodone", (if8_4.done) === (1'b0), if8_4.done, 1'b0);
    chk("d4_hold", (if8_4.sum) === (8'h00), if8_4.sum, 8'h00);
    @(negedge clk);
    chk("d4_done", (if8_4.done) === (1'b1), if8_4.done, 1'b1);
    chk("d4_idle", (if8_4.busy) === (1'b0), if8_4.busy, 1'b0);
    chk("d4_sum", (if8_4.sum) === (8'h01), if8_4.sum, 8'h01);
    chk("d4_cout", (if8_4.cout) === (1'b1), if8_4.cout, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("d4_ovf", (if8_4.ovf) === (1'b0), if8_4.ovf, 1'b0);
`endif
    @(negedge clk);
    chk("d4_done_clr", (if8_4.done) === (1'b0), if8_4.done, 1'b0);

    // DIGIT=1 directed operations, issued back to back
    run8("add_ff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("sub_0507", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run8("add_7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("sub_cin_ign", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);

    // Busy-ignore: a second start mid-RUN must not disturb 12+34
    if8_1.a = 8'h12; if8_1.b = 8'h34; if8_1.cin = 1'b0; if8_1.sub = 1'b0;
    if8_1.start = 1'b1;
    @(negedge clk);
    if8_1.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) begin
        if8_1.a = 8'hFF; if8_1.b = 8'hFF; if8_1.cin = 1'b1; if8_1.sub = 1'b1;
        if8_1.start = 1'b1;
      end else begin
        if8_1.start = 1'b0;
      end
      if (k < 8) begin
        chk("ign_nodone", (if8_1.done) === (1'b0), if8_1.done, 1'b0);
      end
    end
    chk("ign_done", (if8_1.done) === (1'b1), if8_1.done, 1'b1);
    chk("ign_sum", (if8_1.sum) === (8'h46), if8_1.sum, 8'h46);
    chk("ign_cout", (if8_1.cout) === (1'b0), if8_1.cout, 1'b0);
    last_sum8 = 8'h46;
    // Start in the done cycle: accepted, completes STEPS+1 edges later
    run8("b2b_8080", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
    @(negedge clk);
    chk("b2b_done_clr", (if8_1.done) === (1'b0), if8_1.done, 1'b0);

    // Reset on the third RUN edge aborts with no done pulse
    if8_1.a = 8'hAA; if8_1.b = 8'h11; if8_1.cin = 1'b0; if8_1.sub = 1'b0;
    if8_1.start = 1'b1;
    @(negedge clk);
    if8_1.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", (if8_1.busy) === (1'b0), if8_1.busy, 1'b0);
    chk("abort_done", (if8_1.done) === (1'b0), if8_1.done, 1'b0);
    chk("abort_sum", (if8_1.sum) === (8'h00), if8_1.sum, 8'h00);
    chk("abort_cout", (if8_1.cout) === (1'b0), if8_1.cout, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_nodone", (if8_1.done) === (1'b0), if8_1.done, 1'b0);
    end
    last_sum8 = 8'h00;
    run8("fresh_aa11", 8'hAA, 8'h11, 1'b0, 1'b0, 8'hBB, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 over DIGIT 1/2/4 in lockstep
    for (int sv = 0; sv < 2; sv++) begin
      for (int ci = 0; ci < 2; ci++) begin
        for (int ai = 0; ai < 16; ai++) begin
          for (int bi = 0; bi < 16; bi++) begin
            bb4   = (sv == 1) ? ~4'(bi) : 4'(bi);
            exp4  = {1'b0, 4'(ai)} + {1'b0, bb4} + ((sv == 1) ? 5'd1 : 5'(ci));
            eovf4 = (4'(ai) >> 3 == bb4 >> 3) && (exp4[3] != 1'((ai >> 3) & 1));
            if4_1.a = 4'(ai); if4_2.a = 4'(ai); if4_4.a = 4'(ai);
            if4_1.b = 4'(bi); if4_2.b = 4'(bi); if4_4.b = 4'(bi);
            if4_1.cin = 1'(ci); if4_2.cin = 1'(ci); if4_4.cin = 1'(ci);
            if4_1.sub = 1'(sv); if4_2.sub = 1'(sv); if4_4.sub = 1'(sv);
            if4_1.start = 1'b1; if4_2.start = 1'b1; if4_4.start = 1'b1;
            @(negedge clk);
            if4_1.start = 1'b0; if4_2.start = 1'b0; if4_4.start = 1'b0;
            for (int n = 0; n <= 4; n++) begin
              if (n > 0) @(negedge clk);
              for (int i = 0; i < 3; i++) begin
                chk("ex_done", (d4[i]) === (1'(n == steps4[i])), d4[i], 1'(n == steps4[i]));
                chk("ex_busy", (bz4[i]) === (1'(n < steps4[i])), bz4[i], 1'(n < steps4[i]));
                chk("ex_sum", (s4[i]) === ((n >= steps4[i]) ? exp4[3:0] : old4[3:0]),
                    s4[i], (n >= steps4[i]) ? exp4[3:0] : old4[3:0]);
                if (n == steps4[i]) begin
                  chk("ex_cout", (c4[i]) === (exp4[4]), c4[i], exp4[4]);
                end
              end
            end
`ifdef SERIAL_ADDER_OVF_EN
            chk("ex_ovf1", (if4_1.ovf) === (eovf4), if4_1.ovf, eovf4);
            chk("ex_ovf2", (if4_2.ovf) === (eovf4), if4_2.ovf, eovf4);
            chk("ex_ovf4", (if4_4.ovf) === (eovf4), if4_4.ovf, eovf4);
`endif
            old4 = exp4;
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It is the sequential successor to the single-bit full adder cell.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, reusing one DIGIT-bit full-adder slice and a carry register.
- Uses a start/busy/done handshake. Serves as an area-lean arithmetic unit for datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. STEPS = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only when busy=0.
- sub  input  1  0: a+b+cin; 1: a−b (a + ~b + 1; cin ignored).
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  result, held between operations.
- cout  output  1  carry-out of the MSB (for sub: 1 = no borrow).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state←IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, carry register and step counter are cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN.
- Transition IDLE→RUN:
  - Occurs on an edge with start=1.
  - At that edge: A_sh←a; B_sh←(sub ? ~b : b); carry←(sub ? 1 : cin); count←0; busy←1.
- RUN, each edge:
  - Adds the low DIGIT bits of A_sh, B_sh and carry.
  - Shifts A_sh/B_sh right by DIGIT.
  - Shifts the DIGIT result bits into the top of an internal result register R.
  - carry←digit carry-out; count←count+1.
- Transition RUN→IDLE:
  - Occurs on the edge where count==STEPS−1 (the STEPS-th RUN edge).
  - At that edge: sum←final R (including the current digit); cout←final carry; done←1; busy←0.
- Latency:
  - start sampled at edge t0 → done=1 in the cycle after edge t0+STEPS.
  - done clears at edge t0+STEPS+1.
  - Throughput is one operation per STEPS+1 cycles.
- start while busy=1 is ignored: no queuing, no effect on the current operation.
- a, b, cin and sub may change freely after the accepting edge.
- start=1 in the cycle where done=1 is accepted (state is IDLE), so back-to-back operations are allowed.
- sum and cout hold their previous values during RUN. They change only on the completion edge or on reset.
- done is never high while busy is high.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the exact result.
- The step counter is $clog2(STEPS)+1 bits.
- STEPS==1 (DIGIT==WIDTH) is legal: one RUN cycle, done one cycle after start.
- X on start while rst=0 is a bench error; the RTL need not tolerate it.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (output, 1 bit) = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - The carry into the MSB is taken from the final digit's internal carry chain.
  - ovf is updated together with sum/cout on the completion edge; reset value 0; held otherwise.
- When undefined:
  - The port ovf does not exist.
  - No overflow logic is generated.

Test Plan:
- WIDTH=8, DIGIT=1:
  - start, a=8'hFF, b=8'h01, cin=0, sub=0 → done in the cycle after the 8th edge following start; sum=8'h00, cout=1.
  - sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0 (borrow).
  - a=8'h7F, b=8'h01, sub=0, with SERIAL_ADDER_OVF_EN → sum=8'h80, cout=0, ovf=1.
- WIDTH=8, DIGIT=4, a=8'h3C, b=8'hC4, cin=1 → done after 2 RUN edges; sum=8'h01, cout=1.
- Busy-ignore and back-to-back:
  - Pulse start mid-RUN with different operands → the first result is unaffected; no extra done.
  - Then assert start in the done cycle → second operation accepted; its done arrives STEPS+1 edges later.
- Reset: assert rst on the 3rd RUN edge → busy=0, done=0, sum=0, cout=0 next cycle; no done pulse. A fresh start then completes correctly.
- Exhaustive WIDTH=4, DIGIT∈{1,2,4}: all a, b, cin, sub combinations → sum/cout match a reference model; sum stays stable during RUN.
